// File: rtl/cache_fill_fsm_pkg.sv
// Shared cache definitions: fill-controller state encoding and block geometry.
// The tag array controller imports the same constants.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int WORDS    = 8;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 3;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word-index counter with synchronous clear, increment enable and terminal count.
module fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [INDEX_W-1:0] count,
  output logic               tc
);

  logic [INDEX_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == {INDEX_W{1'b1}});

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss refill controller: issues eight pipelined block reads and writes
// each returned word into the data array, then pulses the tag write.
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data_out,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [WORDS-1:0]  word_enable,
  output logic [15:0]       data_to_array,
  output logic              write_tag_array
);

  import cache_fill_fsm_pkg::*;

  fill_state_e                state_reg;
  logic                       busy_reg;
  logic                       issue_done_reg;
  logic [ADDR_W-OFFSET_W-1:0] base_reg;

  logic               accept;
  logic [INDEX_W-1:0] issue_cnt;
  logic [INDEX_W-1:0] recv_cnt;
  logic               issue_tc;
  logic               recv_tc;

  assign accept = (state_reg == IDLE) && miss_detected;

  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (memory_read),
    .count (issue_cnt),
    .tc    (issue_tc)
  );

  fill_counter u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (write_data_array),
    .count (recv_cnt),
    .tc    (recv_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      issue_done_reg <= 1'b0;
      base_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss_detected) begin
            state_reg      <= FILL;
            busy_reg       <= 1'b1;
            issue_done_reg <= 1'b0;
            base_reg       <= miss_address[ADDR_W-1:OFFSET_W];
          end
        end
        FILL: begin
          if (memory_read && issue_tc) begin
            issue_done_reg <= 1'b1;
          end
          if (write_tag_array) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_busy       = busy_reg;
  assign memory_read    = busy_reg && !issue_done_reg;
  // Only the word index advances, so the block base never picks up a carry.
  assign memory_address = {base_reg, issue_cnt, 1'b0};

  // Write side is combinational on the returned valid for zero added latency.
  assign write_data_array = busy_reg && memory_data_valid;
  assign write_tag_array  = write_data_array && recv_tc;
  assign data_to_array    = memory_data_out;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_en
    assign word_enable[gi] = write_data_array && (recv_cnt == INDEX_W'(gi));
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a latency/gap memory model drives returns,
// expected reads and array writes are queued and compared as the DUT produces them.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_out;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [7:0]  word_enable;
  logic [15:0] data_to_array;
  logic        write_tag_array;

  cache_fill_fsm #(.ADDR_W(16), .WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data_out   (memory_data_out),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_enable       (word_enable),
    .data_to_array     (data_to_array),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ready;
    logic [15:0] data;
  } mem_rsp_t;

  typedef struct {
    logic [7:0]  en;
    logic [15:0] data;
    logic        tag;
  } wr_exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc;
  logic        model_busy;
  int          rx_idx;
  int          fill_valids;
  logic [15:0] exp_rd_q[$];
  wr_exp_t     exp_wr_q[$];
  mem_rsp_t    mem_q[$];
  int          lat       = 4;
  int          gap_after = 0;
  int          gap_len   = 0;
  int          gap_cnt   = 0;
  logic        spur      = 1'b0;
  int          busy_cycles;
  int          first_rd_cyc;
  int          first_wr_cyc;
  int          tag_cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic run_cycle(input logic rst_in, input logic miss_in, input logic [15:0] addr_in);
    logic        drive_v;
    logic [15:0] d;
    logic        exp_wr;
    wr_exp_t     w;
    logic [15:0] a;
    @(posedge clk);
    #1;
    cyc++;
    rst           = rst_in;
    miss_detected = miss_in;
    miss_address  = addr_in;
    drive_v = 1'b0;
    d       = 16'($urandom);
    if (gap_cnt > 0) begin
      gap_cnt--;
    end else if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      drive_v = 1'b1;
      d       = mem_q[0].data;
      void'(mem_q.pop_front());
    end else if (spur) begin
      drive_v = 1'b1;
    end
    memory_data_valid = drive_v;
    memory_data_out   = d;
    exp_wr = drive_v && model_busy;
    if (exp_wr) exp_wr_q.push_back('{8'(1 << rx_idx), d, rx_idx == 7});
    #1;
    check_val("busy", fsm_busy, model_busy);
    check_val("write", write_data_array, exp_wr);
    if (exp_wr && exp_wr_q.size() > 0) begin
      w = exp_wr_q.pop_front();
      check_val("word_en", word_enable, w.en);
      check_val("wr_data", data_to_array, w.data);
      check_val("tag", write_tag_array, w.tag);
    end else begin
      check_val("word_en_idle", word_enable, 8'h00);
      check_val("tag_idle", write_tag_array, 1'b0);
    end
    check_val("en_onehot", $onehot0(word_enable) && (word_enable == 8'h00 || write_data_array), 1'b1);
    check_val("read", memory_read, model_busy && exp_rd_q.size() > 0);
    if (memory_read && exp_rd_q.size() > 0) begin
      a = exp_rd_q.pop_front();
      check_val("rd_addr", memory_address, a);
      mem_q.push_back('{cyc + lat, memory_address ^ 16'h5A3C});
    end
    if (fsm_busy) busy_cycles++;
    if (memory_read && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (write_data_array && first_wr_cyc < 0) first_wr_cyc = cyc;
    if (write_tag_array) tag_cyc = cyc;
    if (rst_in) begin
      model_busy = 1'b0;
      rx_idx     = 0;
      gap_cnt    = 0;
      exp_rd_q.delete();
      mem_q.delete();
    end else if (!model_busy) begin
      if (miss_in) begin
        model_busy  = 1'b1;
        rx_idx      = 0;
        fill_valids = 0;
        for (int i = 0; i < 8; i++) exp_rd_q.push_back({addr_in[15:4], 3'(i), 1'b0});
      end
    end else if (drive_v) begin
      fill_valids++;
      if (gap_after != 0 && fill_valids == gap_after) gap_cnt = gap_len;
      if (rx_idx == 7) model_busy = 1'b0;
      rx_idx = (rx_idx + 1) % 8;
    end
  endtask

  task automatic start_window();
    cyc          = -1;
    busy_cycles  = 0;
    first_rd_cyc = -1;
    first_wr_cyc = -1;
    tag_cyc      = -1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((model_busy || exp_rd_q.size() > 0 || mem_q.size() > 0) && n < 60) begin
      run_cycle(1'b0, 1'b0, 16'h0000);
      n++;
    end
    check_val({tag, "_timeout"}, n < 60, 1'b1);
  endtask

  task automatic run_fill(input string tag, input logic [15:0] addr, input int exp_busy, input int exp_tag);
    start_window();
    run_cycle(1'b0, 1'b1, addr);
    drain(tag);
    check_val({tag, "_busy_len"}, busy_cycles, exp_busy);
    check_val({tag, "_tag_cyc"}, tag_cyc, exp_tag);
    check_val({tag, "_first_rd"}, first_rd_cyc, 1);
    check_val({tag, "_first_wr"}, first_wr_cyc, 5);
    run_cycle(1'b0, 1'b0, 16'h0000);
    $display("fill %s addr=0x%04h busy=%0d tag_cycle=%0d", tag, addr, busy_cycles, tag_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data_out   = 16'h0000;
    model_busy        = 1'b0;
    rx_idx            = 0;
    fill_valids       = 0;
    cyc               = 0;
    start_window();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("rst_busy", fsm_busy, 1'b0);
    check_val("rst_read", memory_read, 1'b0);
    check_val("rst_addr", memory_address, 16'h0000);
    check_val("rst_write", write_data_array, 1'b0);
    check_val("rst_en", word_enable, 8'h00);
    check_val("rst_tag", write_tag_array, 1'b0);

    // Basic fill with 4-cycle memory.
    run_fill("basic", 16'h1236, 12, 12);

    // Valid stream pauses 3 cycles after the 4th word.
    gap_after = 4;
    gap_len   = 3;
    run_fill("gapped", 16'h4A50, 15, 15);
    gap_after = 0;

    // Miss held through the fill; address changes mid-fill must be ignored.
    start_window();
    for (int i = 0; i < 14; i++) begin
      run_cycle(1'b0, 1'b1, (i == 0 || i == 13) ? 16'hFFF0 : 16'($urandom));
    end
    check_val("held_tag_cyc", tag_cyc, 12);
    run_cycle(1'b0, 1'b0, 16'h0000);
    check_val("held_refill_busy", fsm_busy, 1'b1);
    drain("held");
    run_cycle(1'b0, 1'b0, 16'h0000);
    $display("fill held addr=0xFFF0 busy=%0d (two fills)", busy_cycles);

    // Spurious valids while idle.
    spur = 1'b1;
    repeat (5) run_cycle(1'b0, 1'b0, 16'h0000);
    spur = 1'b0;
    $display("idle spurious valid window done");

    // Reset in cycle 7 of a fill, then a clean restart.
    start_window();
    run_cycle(1'b0, 1'b1, 16'h2468);
    for (int i = 1; i < 7; i++) run_cycle(1'b0, 1'b0, 16'h0000);
    run_cycle(1'b1, 1'b0, 16'h0000);
    spur = 1'b1;
    repeat (5) run_cycle(1'b0, 1'b0, 16'h0000);
    spur = 1'b0;
    check_val("abort_no_tag", tag_cyc, -1);
    $display("fill abort addr=0x2468 reset at cycle 7");
    run_fill("restart", 16'h0ABC, 12, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that refills one cache block from main memory and writes it into the cache data array one word per cycle. It is the writer side of the data array: it issues eight pipelined memory reads for the missing block, steers each returned word into the array with a one-hot word enable, and updates the tag array when the last word lands. It sits between the cache hit/miss logic and the shared memory port; the cache stalls the pipeline while `fsm_busy` is high.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width.
- `WORDS`, 8: 16-bit words per block; the block offset is addr[3:0] and the word index is addr[3:1].

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss_detected`  in  1  request a fill for `miss_address`; sampled only in IDLE.
- `miss_address`  in  16  byte address that missed.
- `memory_data_valid`  in  1  `memory_data_out` holds a returned word this cycle.
- `memory_data_out`  in  16  word returned by memory.
- `fsm_busy`  out  1  fill in progress; the pipeline stalls.
- `memory_read`  out  1  issue a read of `memory_address` this cycle.
- `memory_address`  out  16  read address, {block base[15:4], issue index[2:0], 1'b0}.
- `write_data_array`  out  1  write `data_to_array` into the enabled word.
- `word_enable`  out  8  one-hot word select; all zeros when not writing.
- `data_to_array`  out  16  equals `memory_data_out`, combinational pass-through.
- `write_tag_array`  out  1  one-cycle pulse; write the tag and set the valid bit for the block.

## Operation
- States: IDLE and FILL, held in a registered state.
- In IDLE with `miss_detected`=1:
  - latch `miss_address[15:4]` as the block base;
  - clear `issue_cnt` and `recv_cnt` (3-bit each) and `issue_done`;
  - next state is FILL.
- FILL, issue side:
  - `memory_read`=1 while `issue_done`=0.
  - `memory_address` = {base, issue_cnt, 0}.
  - `issue_cnt` increments each cycle. When it reaches 7 and that read issues, `issue_done` sets.
  - Exactly 8 reads are issued, in order, for word indices 0..7.
- FILL, receive side, on each `memory_data_valid`=1:
  - `write_data_array`=1.
  - `word_enable` = 1<<`recv_cnt`.
  - `recv_cnt` increments.
- Last word: on the valid with `recv_cnt`=7, `write_tag_array`=1 in the same cycle and the next state is IDLE.
- Ignored inputs:
  - `miss_detected` while in FILL;
  - `memory_data_valid` while in IDLE (no array write);
  - `miss_address` changes during FILL (the base is latched).
- Issue and receive may overlap in the same cycle; the two counters are independent.
- Address arithmetic: the base is never incremented. The word index alone wraps within the block, so no carry reaches bits [15:4].

## Timing
- Reset values: state IDLE, all counters 0, `fsm_busy`=0, `memory_read`=0, `write_data_array`=0, `word_enable`=0, `write_tag_array`=0, `memory_address`=0.
- `fsm_busy` = (state==FILL). It rises in the cycle after the miss is sampled and falls in the cycle after `write_tag_array`.
- Reads issue on the 8 consecutive cycles starting with the first FILL cycle.
- Array writes are combinational on `memory_data_valid`, giving zero added latency.
- Fill duration is 8 plus the memory latency, plus any gaps in the valid stream. With 4-cycle memory, busy lasts 12 cycles.
- `rst` during FILL: the next cycle is IDLE with no further reads or writes. Words already written stay in the array and the tag is not written, so the block remains invalid.
- A miss asserted in the same cycle as `write_tag_array` is ignored; it is accepted the following cycle, when the state is IDLE.

## Structure
- Shared cache package holds the state encoding (IDLE=0, FILL=1), `WORDS`, the block-offset width (4), and the word-index width (3). The tag array controller also uses these.
- One sub-module, `fill_counter`: 3-bit counter with clear, increment enable, and a terminal-count output. It is instantiated twice, for issue and for receive.
- One-hot decode of `recv_cnt` is inline.

## Test plan
- Basic fill, 4-cycle memory model, miss at cycle 0 with address 0x1236:
  - reads at cycles 1..8 to 0x1230, 0x1232, …, 0x123E;
  - writes at cycles 5..12 with `word_enable` 0x01..0x80;
  - `write_tag_array` at cycle 12;
  - `fsm_busy` high for cycles 1..12.
- Gapped return, with valid deasserted for 3 cycles after the 4th word: writes stay in order 0..7, the tag pulse comes on the 8th valid, and busy extends by 3 cycles.
- `miss_detected` held high throughout a fill at address 0xFFF0:
  - only 8 reads, the last to 0xFFFE with no wrap into the tag bits;
  - a second fill starts one cycle after busy falls.
- Spurious `memory_data_valid` in IDLE: `write_data_array`, `word_enable` and `write_tag_array` all stay 0.
- `rst` asserted at cycle 7 of a fill: from cycle 8, `fsm_busy`=0 and no reads, writes or tag pulse occur; a new miss afterwards restarts at word 0.
- Continuous check across all tests: `word_enable` is one-hot or zero, and it is nonzero only when `write_data_array`=1.
